// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: counts q down to terminal count, pulses tc for one cycle,
// then either stops in IDLE (one-shot) or reloads and keeps running (periodic).
module down_counter_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             auto_reload,
   input  logic             en,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             busy
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_q;
   logic             r_tc;
   logic [WIDTH-1:0] r_reload;
   logic             r_mode;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_tc_nxt;
   logic [WIDTH-1:0] w_reload_nxt;
   logic             w_mode_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_q      <= '0;
         r_tc     <= 1'b0;
         r_reload <= '0;
         r_mode   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_q      <= w_q_nxt;
         r_tc     <= w_tc_nxt;
         r_reload <= w_reload_nxt;
         r_mode   <= w_mode_nxt;
      end
   end

   // Load outranks terminal count; RUN always holds q >= 1, so no underflow path exists.
   always_comb begin
      w_state_nxt  = r_state;
      w_q_nxt      = r_q;
      w_tc_nxt     = 1'b0;
      w_reload_nxt = r_reload;
      w_mode_nxt   = r_mode;
      if (load) begin
         w_q_nxt      = load_val;
         w_reload_nxt = load_val;
         w_mode_nxt   = auto_reload;
         w_state_nxt  = (load_val != '0) ? S_RUN : S_IDLE;
      end else if (r_state == S_RUN && en) begin
         if (r_q == WIDTH'(1)) begin
            w_tc_nxt = 1'b1;
            if (r_mode) begin
               w_q_nxt = r_reload;
            end else begin
               w_q_nxt     = '0;
               w_state_nxt = S_IDLE;
            end
         end else begin
            w_q_nxt = r_q - WIDTH'(1);
         end
      end
   end

   always_comb begin
      q    = r_q;
      tc   = r_tc;
      busy = (r_state == S_RUN);
   end

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: expected q/tc/busy pushed per driven cycle,
// popped and compared on the following falling edge, plus directed sequence checks.
module tb_down_counter_timer;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         load;
   logic [W-1:0] load_val;
   logic         auto_reload;
   logic         en;
   logic [W-1:0] q;
   logic         tc;
   logic         busy;

   down_counter_timer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val),
      .auto_reload(auto_reload), .en(en), .q(q), .tc(tc), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] q;
      logic         tc;
      logic         busy;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   int   m_q, m_reload;
   bit   m_tc, m_busy, m_mode;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q = 0; m_reload = 0; m_tc = 0; m_busy = 0; m_mode = 0;
   endtask

   // Reference behaviour of one rising edge, written from the timer's rules.
   task automatic model_step(input bit ld, input int lv, input bit ar, input bit e);
      if (ld) begin
         m_q = lv; m_reload = lv; m_mode = ar; m_tc = 0; m_busy = (lv != 0);
      end else if (m_busy && e && m_q == 1) begin
         m_tc = 1;
         if (m_mode) m_q = m_reload;
         else begin m_q = 0; m_busy = 0; end
      end else begin
         m_tc = 0;
         if (m_busy && e) m_q = m_q - 1;
      end
   endtask

   // Drive inputs for one cycle (called just after a falling edge), score the result.
   task automatic cycle(input bit ld, input logic [W-1:0] lv, input bit ar, input bit e);
      exp_t x;
      load = ld; load_val = lv; auto_reload = ar; en = e;
      model_step(ld, int'(lv), ar, e);
      x.q = W'(m_q); x.tc = m_tc; x.busy = m_busy;
      sb.push_back(x);
      @(posedge clk);
      @(negedge clk);
      x = sb.pop_front();
      chk("q", q, x.q);
      chk("tc", tc, x.tc);
      chk("busy", busy, x.busy);
   endtask

   initial begin
      int seq1[5];
      int cnt;
      bit seen;
      seq1 = '{4, 3, 2, 1, 0};

      rst = 1'b1; load = 0; load_val = '0; auto_reload = 0; en = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("rst_q", q, 0);
      chk("rst_tc", tc, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;

      // 1: one-shot from 5
      cycle(1, 5, 0, 1);
      chk("t1_load_q", q, 5);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 0, 1);
         chk("t1_seq_q", q, seq1[i]);
         chk("t1_seq_tc", tc, (i == 4));
      end
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      chk("t1_hold_q", q, 0);
      chk("t1_hold_busy", busy, 0);

      // 2: periodic 3
      cycle(1, 3, 1, 1);
      for (int i = 0; i < 10; i++) begin
         cycle(0, 0, 0, 1);
         chk("t2_q", q, 2 - (i % 3) == 0 ? 3 : (i % 3 == 2 ? 3 : 2 - (i % 3)));
         chk("t2_tc", tc, (i % 3) == 2);
         chk("t2_busy", busy, 1);
      end

      // 3: one-shot 4 with en toggling
      cycle(1, 4, 0, 0);
      cnt = 0; seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cycle(0, 0, 0, (i % 2) == 0);
         if ((i % 2) == 0) cnt++;
         if (tc) seen = 1;
      end
      chk("t3_tc_seen", seen, 1);
      chk("t3_en_cycles", cnt, 4);

      // 4: load overrides decrement and terminal count
      cycle(1, 6, 0, 1);
      repeat (4) cycle(0, 0, 0, 1);
      chk("t4_at2", q, 2);
      cycle(1, 9, 0, 1);
      chk("t4_reload_q", q, 9);
      chk("t4_reload_tc", tc, 0);
      repeat (8) cycle(0, 0, 0, 1);
      chk("t4_at1", q, 1);
      cycle(1, 4, 0, 1);
      chk("t4_tc_blocked", tc, 0);
      chk("t4_q4", q, 4);
      repeat (5) cycle(0, 0, 0, 1);

      // 5: zero load and full-scale load
      cycle(1, 0, 0, 1);
      chk("t5_zero_busy", busy, 0);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 0, 1);
         if (tc) seen = 1;
      end
      chk("t5_zero_no_tc", seen, 0);
      cycle(1, 15, 0, 0);
      cnt = 0; seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cycle(0, 0, 0, 1);
         cnt++;
         if (tc) seen = 1;
      end
      chk("t5_full_seen", seen, 1);
      chk("t5_full_cycles", cnt, 15);

      // 6: async reset mid periodic count
      cycle(1, 9, 1, 1);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      chk("t6_at7", q, 7);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_q", q, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_tc", tc, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) cycle(0, 0, 0, 1);

      // Random mix
      for (int i = 0; i < 300; i++) begin
         cycle($urandom_range(0, 9) == 0, W'($urandom), $urandom_range(0, 1),
               $urandom_range(0, 3) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Loadable synchronous down-counter/timer. It is the counting-down counterpart to the team's 4-bit up counter and shares the same `clk`/`rst` convention. Software or an FSM loads a start value, and the block decrements on enabled cycles. At terminal count it emits a one-cycle `tc` pulse, then either stops (one-shot) or reloads (periodic). It is used as a timeout or period generator next to the up counter in small control datapaths.

Parameters:
WIDTH, 4, counter and load-value width in bits (legal range 2..32).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset; clears all state immediately.
load  input  1  load strobe; sampled on the rising edge of `clk`.
load_val  input  WIDTH  start/reload value, captured when `load`=1.
auto_reload  input  1  mode select, captured when `load`=1: 0 = one-shot, 1 = periodic.
en  input  1  count enable; decrement occurs only when `en`=1 in RUN.
q  output  WIDTH  current count, registered.
tc  output  1  terminal-count pulse, registered, high for exactly one cycle.
busy  output  1  high while in RUN.

Behaviour:
- Reset (`rst`=1, asynchronous): `q`=0, `tc`=0, `busy`=0, state=IDLE, reload register=0, mode register=0. These values hold for as long as `rst` is high. First action is on the first rising edge after `rst` falls.
- States: IDLE (`busy`=0) and RUN (`busy`=1). `busy` is a registered decode of the state.
- `load`=1 (any state, highest priority below reset):
  - `q` <= `load_val`, reload register <= `load_val`, mode <= `auto_reload`, `tc` <= 0.
  - Next state is RUN if `load_val` != 0, else IDLE.
  - Latency: value visible on `q` one edge after the `load` edge.
  - A `load` that coincides with a would-be terminal count wins; no `tc` is produced.
- IDLE, `load`=0: `q` holds and `en` is ignored.
- RUN, `load`=0, `en`=0: `q` holds and `tc` <= 0.
- RUN, `load`=0, `en`=1, `q`>1: `q` <= `q`-1.
- RUN, `load`=0, `en`=1, `q`==1 (terminal count):
  - `tc` <= 1 for one cycle.
  - One-shot mode: `q` <= 0, state <= IDLE.
  - Periodic mode: `q` <= reload register, state stays RUN.
  - In periodic mode `q` never shows 0. The `tc` period equals the reload value in enabled cycles; a reload value of 1 gives `tc` on every enabled cycle.
- `tc` is deasserted on every edge where no terminal count occurs, so it is never high for two consecutive cycles. The exception is periodic mode with reload=1 and `en` held high.
- Arithmetic is unsigned WIDTH-bit. There is no underflow, because decrement never occurs from 0: in RUN, `q` is always ≥1.
- The maximum load value (2^WIDTH−1) is legal and counts fully down.
- Reset asserted mid-count aborts immediately, with no `tc`. After release the block sits in IDLE until the next `load`.
- `auto_reload` and `load_val` are don't-care when `load`=0.

Test Plan:
1. Reset, then `load`=1 with `load_val`=5 and `auto_reload`=0, followed by `en`=1 constantly → `q` = 5,4,3,2,1,0 on consecutive edges. `tc`=1 only in the cycle `q` becomes 0. `busy` falls with it and `q` holds 0 afterwards.
2. `load_val`=3, `auto_reload`=1, `en`=1 for 10 cycles → `q` = 3,2,1,3,2,1,3,…. `tc` pulses in every cycle where `q` returns to 3 (every 3 cycles), and `busy` stays 1.
3. `load_val`=4, one-shot, `en` toggling 1,0,1,0,… → `q` decrements only on `en`=1 edges, and `tc` fires after exactly 4 enabled cycles.
4. Load 6, count down to 2, then `load`=1 with `load_val`=9 in the same cycle that `en`=1 → `q`=9 next, with no decrement that cycle and no `tc`. Also, `load` in the cycle `q`==1 with `en`=1 → no `tc`.
5. Load `load_val`=0 → `q`=0, `busy`=0, `tc` never asserts. Load 15 (WIDTH=4) → 15 enabled cycles to `tc`.
6. Periodic count at `q`=7 with `rst` pulsed mid-cycle (asynchronously) → `q`=0, `busy`=0, `tc`=0 immediately. No activity occurs until the next `load`.
